dmem_arbiter: RTL and testbench

- Two-requester arbiter in front of the 1024x32 data memory (async read, sync write).
- Shares the single memory port between the CPU load/store stage and a host/loader port used for program and data preload and for result dump.
- Round-robin arbitration with a bounded host burst lock; read data is returned registered.
- Drives the memory's a/d/dpra/we pins directly.

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester (CPU / host loader) arbiter in front of a
// 1024x32 data memory with async read and sync write. Round-robin on
// contention, with a bounded host burst lock. Read data is returned
// registered one cycle after the accepting edge.
// Optional build macro: DMEM_ARB_STATS_EN adds the cpu_stall_cnt output.
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [ADDR_W-1:0] mem_dpra,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dpo
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       cpu_stall_cnt
`endif
);

  // Owner of the previous cycle's grant.
  typedef enum logic [1:0] {
    IDLE,
    CPU_OWN,
    HOST_OWN,
    HOST_LOCK
  } state_e;

  localparam logic [7:0] LockMax = 8'(LOCK_MAX);

  state_e              state_q, state_d;
  logic [7:0]          lock_cnt_q, lock_cnt_d;
  logic                cpu_rvalid_q, host_rvalid_q;
  logic [DATA_W-1:0]   cpu_rdata_q, host_rdata_q;

  // Grant decision: single requester always wins; contention alternates
  // unless the host holds a lock that has not yet used its budget.
  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (!rst) begin
      if (cpu_req && !host_req) begin
        cpu_gnt = 1'b1;
      end else if (host_req && !cpu_req) begin
        host_gnt = 1'b1;
      end else if (cpu_req && host_req) begin
        case (state_q)
          CPU_OWN:   host_gnt = 1'b1;
          HOST_LOCK: begin
            if (lock_cnt_q < LockMax) host_gnt = 1'b1;
            else                      cpu_gnt  = 1'b1;
          end
          default:   cpu_gnt = 1'b1;
        endcase
      end
    end
  end

  // Next owner state and burst-lock budget counter.
  always_comb begin
    state_d = IDLE;
    if (cpu_gnt)       state_d = CPU_OWN;
    else if (host_gnt) state_d = host_lock ? HOST_LOCK : HOST_OWN;

    lock_cnt_d = lock_cnt_q;
    if (cpu_gnt || !host_lock) begin
      lock_cnt_d = '0;
    end else if (host_gnt && cpu_req && lock_cnt_q != 8'hFF) begin
      lock_cnt_d = lock_cnt_q + 8'd1;
    end
  end

  // Memory pin drive from whichever requester holds the grant.
  always_comb begin
    mem_a  = '0;
    mem_d  = '0;
    mem_we = 1'b0;
    if (cpu_gnt) begin
      mem_a  = cpu_addr;
      mem_d  = cpu_wdata;
      mem_we = cpu_we;
    end else if (host_gnt) begin
      mem_a  = host_addr;
      mem_d  = host_wdata;
      mem_we = host_we;
    end
  end

  assign mem_dpra = mem_a;

  // Owner FSM, lock counter and registered read-return path.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      lock_cnt_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
      cpu_rdata_q   <= '0;
      host_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      lock_cnt_q    <= lock_cnt_d;
      cpu_rvalid_q  <= cpu_gnt && !cpu_we;
      host_rvalid_q <= host_gnt && !host_we;
      if (cpu_gnt && !cpu_we)   cpu_rdata_q  <= mem_dpo;
      if (host_gnt && !host_we) host_rdata_q <= mem_dpo;
    end
  end

  assign cpu_rvalid  = cpu_rvalid_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of cycles the CPU requested but was not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (cpu_req && !cpu_gnt && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign cpu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural model of arbitration, memory and read return.
module tb_dmem_arbiter;

  localparam int unsigned LOCK_MAX = 16;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [9:0]  cpu_addr, host_addr;
  logic [31:0] cpu_wdata, host_wdata;
  logic        cpu_gnt, cpu_rvalid, host_gnt, host_rvalid;
  logic [31:0] cpu_rdata, host_rdata;
  logic [9:0]  mem_a, mem_dpra;
  logic [31:0] mem_d, mem_dpo;
  logic        mem_we;
`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_stall_cnt;
`endif

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_a(mem_a), .mem_dpra(mem_dpra), .mem_d(mem_d), .mem_we(mem_we), .mem_dpo(mem_dpo)
`ifdef DMEM_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory attached to the arbiter: async read, sync write.
  logic [31:0] mem [1024];
  always @(posedge clk) if (mem_we) mem[mem_a] <= mem_d;
  assign mem_dpo = mem[mem_dpra];

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          m_last;      // 0 nobody, 1 cpu, 2 host unlocked, 3 host locked
  int          m_streak;    // locked host wins while the CPU was waiting
  bit          m_cpu_rv, m_host_rv;
  logic [31:0] m_cpu_rd, m_host_rd;
  logic [31:0] shadow [1024];
  longint      m_stall;
  int          last_gnt;    // 0 none, 1 cpu, 2 host (for directed sequence checks)

  function automatic logic [31:0] pat(int unsigned i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit cr, input bit cw, input int unsigned ca, input logic [31:0] cd,
                       input bit hr, input bit hw, input int unsigned ha, input logic [31:0] hd,
                       input bit hl);
    cpu_req = cr; cpu_we = cw; cpu_addr = 10'(ca); cpu_wdata = cd;
    host_req = hr; host_we = hw; host_addr = 10'(ha); host_wdata = hd;
    host_lock = hl;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit gc, gh, ewe;
    logic [9:0]  ea;
    logic [31:0] ed;
    gc = 0; gh = 0;
    if (!rst) begin
      if (cpu_req && host_req) begin
        if (m_last == 1) gh = 1;
        else if (m_last == 3 && m_streak < int'(LOCK_MAX)) gh = 1;
        else gc = 1;
      end else begin
        gc = cpu_req;
        gh = host_req;
      end
    end
    ea = '0; ed = '0; ewe = 0;
    if (gc) begin ea = cpu_addr; ed = cpu_wdata; ewe = cpu_we; end
    else if (gh) begin ea = host_addr; ed = host_wdata; ewe = host_we; end
    last_gnt = gc ? 1 : (gh ? 2 : 0);

    @(negedge clk);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(gc));
    chk("host_gnt", 32'(host_gnt), 32'(gh));
    chk("mem_we", 32'(mem_we), 32'(ewe));
    chk("mem_a", 32'(mem_a), 32'(ea));
    chk("mem_dpra", 32'(mem_dpra), 32'(ea));
    chk("mem_d", mem_d, ed);

    @(posedge clk);
    if (rst) begin
      m_last = 0; m_streak = 0; m_cpu_rv = 0; m_host_rv = 0;
      m_cpu_rd = '0; m_host_rd = '0; m_stall = 0;
    end else begin
      m_cpu_rv  = gc && !cpu_we;
      m_host_rv = gh && !host_we;
      if (m_cpu_rv)  m_cpu_rd  = shadow[cpu_addr];
      if (m_host_rv) m_host_rd = shadow[host_addr];
      if (gc && cpu_we)  shadow[cpu_addr]  = cpu_wdata;
      if (gh && host_we) shadow[host_addr] = host_wdata;
      if (gc || !host_lock) m_streak = 0;
      else if (gh && cpu_req) m_streak++;
      m_last = gc ? 1 : (gh ? (host_lock ? 3 : 2) : 0);
      if (cpu_req && !gc && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    #1;
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
    chk("host_rvalid", 32'(host_rvalid), 32'(m_host_rv));
    chk("cpu_rdata", cpu_rdata, m_cpu_rd);
    chk("host_rdata", host_rdata, m_host_rd);
`ifdef DMEM_ARB_STATS_EN
    chk("cpu_stall_cnt", cpu_stall_cnt, 32'(m_stall));
`endif
  endtask

  initial begin
    int run;
    m_last = 0; m_streak = 0; m_cpu_rv = 0; m_host_rv = 0;
    m_cpu_rd = '0; m_host_rd = '0; m_stall = 0; last_gnt = 0;

    // Reset with both requesting writes: no grant, no write.
    rst = 1'b1;
    drive(1, 1, 3, 32'h1111_1111, 1, 1, 4, 32'h2222_2222, 0);
    cycle();
    cycle();
    chk("rst_no_gnt", 32'(last_gnt), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);

    // First cycle out of reset with contention goes to the CPU.
    rst = 1'b0;
    cycle();
    chk("post_rst_cpu_first", 32'(last_gnt), 32'd1);
    cycle();
    chk("post_rst_host_next", 32'(last_gnt), 32'd2);

    // Host preloads the whole memory.
    for (int unsigned i = 0; i < 1024; i++) begin
      drive(0, 0, 0, '0, 1, 1, i, pat(i), 0);
      cycle();
    end

    // Host write then CPU read of the same address on the next cycle.
    drive(0, 0, 0, '0, 1, 1, 5, 32'hDEADBEEF, 0);
    cycle();
    drive(1, 0, 5, '0, 0, 0, 0, '0, 0);
    cycle();
    chk("raw_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("raw_rdata", cpu_rdata, 32'hDEADBEEF);

    // Contention without lock alternates CPU / host.
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    cycle();
    for (int k = 0; k < 8; k++) begin
      drive(1, 0, 1 + k % 4, '0, 1, 0, 1 + k % 4, '0, 0);
      cycle();
      chk("alt_seq", 32'(last_gnt), (k % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Locked host burst: CPU, then LOCK_MAX host grants, then CPU, then host.
    drive(0, 0, 0, '0, 0, 0, 0, '0, 0);
    cycle();
    drive(1, 0, 7, '0, 1, 0, 9, '0, 1);
    cycle();
    chk("lock_first_cpu", 32'(last_gnt), 32'd1);
    run = 0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (last_gnt != 2) break;
      run++;
    end
    chk("lock_host_run", 32'(run), 32'(LOCK_MAX));
    chk("lock_cpu_after", 32'(last_gnt), 32'd1);
    cycle();
    chk("lock_host_again", 32'(last_gnt), 32'd2);

    // Address wrap at the top of memory.
    drive(1, 1, 1023, 32'h12345678, 0, 0, 0, '0, 0);
    cycle();
    drive(1, 0, 1023, '0, 0, 0, 0, '0, 0);
    cycle();
    chk("wrap_rdata", cpu_rdata, 32'h12345678);
    drive(1, 0, 0, '0, 0, 0, 0, '0, 0);
    cycle();
    chk("wrap_addr0", cpu_rdata, pat(0));

    // Reset mid-read drops the pending rvalid.
    drive(1, 0, 10, '0, 1, 0, 11, '0, 0);
    rst = 1'b1;
    cycle();
    chk("mid_rst_rvalid", 32'(cpu_rvalid), 32'd0);
    rst = 1'b0;

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1023), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1023), $urandom,
            $urandom_range(0, 3) != 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
